// File: rtl/sd_dat_rx.sv
// sd_dat_rx: SD DAT0 single-block receiver.
// It checks the start bit, shifts in the data bytes, then compares the serial CRC16 and checks the end bit.
module sd_dat_rx #(
    parameter int BLOCK_BYTES = 512,
    parameter int ADDR_W      = 9,
    parameter int TIMEOUT     = 65535
) (
    input  logic              iclk,
    input  logic              irst,
    input  logic              istart,
    input  logic              idat,
    output logic [7:0]        odata,
    output logic              ovalid,
    output logic [ADDR_W-1:0] oaddr,
    output logic              obusy,
    output logic              odone,
    output logic              ocrc_err,
    output logic              oend_err,
    output logic              otimeout
);
    typedef enum logic [2:0] {IDLE, WAIT_START, DATA, CRC, END} state_t;
    state_t      state, state_d;
    logic [15:0] cnt, crc, rx;
    logic [15:0] crc_next, rx_next;
    logic        cnt_end;

    assign obusy    = state != IDLE;
    assign rx_next  = {rx[14:0], idat};
    assign crc_next = {crc[14:0], 1'b0} ^ ({16{idat ^ crc[15]}} & 16'h1021);

    always_comb begin
        state_d = state;
        cnt_end = 1'b0;
        case (state)
            IDLE: state_d = istart ? WAIT_START : IDLE;
            WAIT_START: begin
                cnt_end = cnt == 16'(TIMEOUT - 1);
                state_d = !idat ? DATA : cnt_end ? IDLE : WAIT_START;
            end
            DATA: begin
                cnt_end = cnt == 16'(BLOCK_BYTES * 8 - 1);
                state_d = cnt_end ? CRC : DATA;
            end
            CRC: begin
                cnt_end = cnt == 16'd15;
                state_d = cnt_end ? END : CRC;
            end
            END: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // cnt restarts on every state change so each phase counts from zero
    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            state    <= IDLE;
            cnt      <= '0;
            crc      <= '0;
            rx       <= '0;
            odata    <= '0;
            oaddr    <= '0;
            ovalid   <= 1'b0;
            odone    <= 1'b0;
            ocrc_err <= 1'b0;
            oend_err <= 1'b0;
            otimeout <= 1'b0;
        end else begin
            state  <= state_d;
            cnt    <= (state_d != state || state == IDLE) ? '0 : cnt + 16'd1;
            ovalid <= 1'b0;
            odone  <= 1'b0;
            case (state)
                IDLE: if (istart) begin
                    ocrc_err <= 1'b0;
                    oend_err <= 1'b0;
                    otimeout <= 1'b0;
                    crc      <= '0;
                    oaddr    <= '0;
                end
                WAIT_START: if (idat && cnt_end) begin
                    otimeout <= 1'b1;
                    odone    <= 1'b1;
                end
                DATA: begin
                    rx  <= rx_next;
                    crc <= crc_next;
                    if (cnt[2:0] == 3'd7) begin
                        ovalid <= 1'b1;
                        odata  <= rx_next[7:0];
                        oaddr  <= ADDR_W'(cnt >> 3);
                    end
                end
                CRC: begin
                    rx <= rx_next;
                    if (cnt_end && rx_next != crc) ocrc_err <= 1'b1;
                end
                END: begin
                    if (!idat) oend_err <= 1'b1;
                    odone <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule
